// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and branch-operand stalls, redirect flushes and cache-miss freeze
// for the 5-stage pipeline. Optional perf counters are enabled by `HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter bit BR_IN_ID = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic              ifid_is_branch,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_memread,
  input  logic              br_taken,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  cnt_lu,
  output logic [CNT_W-1:0]  cnt_br,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_frz
);

  typedef enum logic {RUN = 1'b0, LB2 = 1'b1} state_t;

  state_t state;
  logic   m_ex, m_mem;
  logic   freeze, load_use, alu_br, load_br, mem_br, br_stall;

  assign m_ex  = (idex_rd != '0) &&
                 ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                  (ifid_use_rs2 && (idex_rd == ifid_rs2)));
  assign m_mem = (exmem_rd != '0) &&
                 ((ifid_use_rs1 && (exmem_rd == ifid_rs1)) ||
                  (ifid_use_rs2 && (exmem_rd == ifid_rs2)));

  assign freeze   = icache_stall || dcache_stall;
  assign load_use = idex_memread && m_ex;

  // Branch-operand stalls only exist when the compare happens in ID.
  assign alu_br   = BR_IN_ID && ifid_is_branch && idex_regwrite && !idex_memread && m_ex;
  assign load_br  = BR_IN_ID && ifid_is_branch && idex_memread && m_ex;
  assign mem_br   = BR_IN_ID && ifid_is_branch && exmem_memread && m_mem && (state == RUN);
  assign br_stall = alu_br || load_br || mem_br;

  // LB2 is the second stall cycle of a load feeding a branch; freeze holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                state <= RUN;
    else if (freeze)        state <= state;
    else if (br_taken)      state <= RUN;
    else if (state == LB2)  state <= RUN;
    else if (load_br)       state <= LB2;
    else                    state <= RUN;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = ~BR_IN_ID;
    end else if ((state == LB2) || load_use || br_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic ev_lu, ev_br, ev_flush, ev_frz;

  // Each cycle falls into at most one category, following the output priority.
  assign ev_frz   = freeze;
  assign ev_flush = !freeze && br_taken;
  assign ev_br    = !freeze && !br_taken && ((state == LB2) || br_stall);
  assign ev_lu    = !freeze && !br_taken && (state == RUN) && !br_stall && load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lu    <= '0;
      cnt_br    <= '0;
      cnt_flush <= '0;
      cnt_frz   <= '0;
    end else begin
      if (ev_lu    && (cnt_lu    != '1)) cnt_lu    <= cnt_lu    + CNT_W'(1);
      if (ev_br    && (cnt_br    != '1)) cnt_br    <= cnt_br    + CNT_W'(1);
      if (ev_flush && (cnt_flush != '1)) cnt_flush <= cnt_flush + CNT_W'(1);
      if (ev_frz   && (cnt_frz   != '1)) cnt_frz   <= cnt_frz   + CNT_W'(1);
    end
  end
`else
  assign cnt_lu    = '0;
  assign cnt_br    = '0;
  assign cnt_flush = '0;
  assign cnt_frz   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: one instance with branches resolved in ID, one in EX,
// both checked against a stall-budget reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd, exmem_rd;
  logic       ifid_use_rs1, ifid_use_rs2, ifid_is_branch;
  logic       idex_regwrite, idex_memread, exmem_memread;
  logic       br_taken, icache_stall, dcache_stall;

  logic       pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, pipe_freeze_a;
  logic       pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, pipe_freeze_b;
  logic [3:0] cnt_lu_a, cnt_br_a, cnt_flush_a, cnt_frz_a;
  logic [3:0] cnt_lu_b, cnt_br_b, cnt_flush_b, cnt_frz_b;

  logic [20:0] obs_a, obs_b, exp_a, exp_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: extra stall cycles still owed per instance, and counters.
  int owed [2];
  int mcnt [2][4];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .BR_IN_ID(1'b1), .CNT_W(4)) dut_id (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ifid_is_branch(ifid_is_branch),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_memread(exmem_memread),
    .br_taken(br_taken), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .pipe_freeze(pipe_freeze_a),
    .cnt_lu(cnt_lu_a), .cnt_br(cnt_br_a), .cnt_flush(cnt_flush_a), .cnt_frz(cnt_frz_a)
  );

  hazard_ctrl #(.REG_AW(5), .BR_IN_ID(1'b0), .CNT_W(4)) dut_ex (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ifid_is_branch(ifid_is_branch),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_memread(exmem_memread),
    .br_taken(br_taken), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .pipe_freeze(pipe_freeze_b),
    .cnt_lu(cnt_lu_b), .cnt_br(cnt_br_b), .cnt_flush(cnt_flush_b), .cnt_frz(cnt_frz_b)
  );

  assign obs_a = {pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, pipe_freeze_a,
                  cnt_lu_a, cnt_br_a, cnt_flush_a, cnt_frz_a};
  assign obs_b = {pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, pipe_freeze_b,
                  cnt_lu_b, cnt_br_b, cnt_flush_b, cnt_frz_b};

  function automatic bit hit(logic [4:0] rd);
    return (rd != 5'd0) && ((ifid_use_rs1 && rd == ifid_rs1) || (ifid_use_rs2 && rd == ifid_rs2));
  endfunction

  // 0 reset, 1 freeze, 2 redirect, 3 owed stall, 4 branch stall, 5 load-use stall, 6 run
  function automatic int classify(int i);
    bit brid = (i == 0);
    if (rst) return 0;
    if (icache_stall || dcache_stall) return 1;
    if (br_taken) return 2;
    if (owed[i] > 0) return 3;
    if (brid && ifid_is_branch &&
        ((hit(idex_rd) && (idex_memread || idex_regwrite)) || (exmem_memread && hit(exmem_rd))))
      return 4;
    if (idex_memread && hit(idex_rd)) return 5;
    return 6;
  endfunction

  function automatic logic [20:0] expect_for(int i);
    int         c = classify(i);
    logic [4:0] o;
    logic [15:0] k;
    case (c)
      0:       o = 5'b00110;
      1:       o = 5'b00001;
      2:       o = (i == 0) ? 5'b11100 : 5'b11110;
      3, 4, 5: o = 5'b00010;
      default: o = 5'b11000;
    endcase
    k = '0;
`ifdef HAZARD_PERF_CNT_EN
    if (c != 0) k = {4'(mcnt[i][0]), 4'(mcnt[i][1]), 4'(mcnt[i][2]), 4'(mcnt[i][3])};
`endif
    return {o, k};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owed[i] = 0;
      for (int j = 0; j < 4; j++) mcnt[i][j] = 0;
    end
  endtask

  task automatic bump(int i, int j);
    if (mcnt[i][j] < 15) mcnt[i][j]++;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 2; i++) begin
      case (classify(i))
        0: model_reset();
        1: bump(i, 3);
        2: begin owed[i] = 0; bump(i, 2); end
        3: begin owed[i]--; bump(i, 1); end
        4: begin
          bump(i, 1);
          if (idex_memread && hit(idex_rd)) owed[i] = 1;
        end
        5: bump(i, 0);
        default: ;
      endcase
    end
  endtask

  task automatic clear_in();
    ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0; ifid_is_branch = 0;
    idex_rd = 0; idex_regwrite = 0; idex_memread = 0; exmem_rd = 0; exmem_memread = 0;
    br_taken = 0; icache_stall = 0; dcache_stall = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    exp_a = expect_for(0);
    exp_b = expect_for(1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // Load x7 in EX feeding a beq in ID.
  task automatic load_branch_in();
    clear_in();
    ifid_is_branch = 1; ifid_rs1 = 7; ifid_use_rs1 = 1; ifid_rs2 = 3; ifid_use_rs2 = 1;
    idex_rd = 7; idex_memread = 1; idex_regwrite = 1;
  endtask

  // Same branch one cycle later: bubble in EX, the load now in MEM.
  task automatic load_in_mem();
    load_branch_in();
    idex_rd = 0; idex_memread = 0; idex_regwrite = 0;
    exmem_rd = 7; exmem_memread = 1;
  endtask

  task automatic test_reset();
    #1;
    clear_in();
    rst = 1;
    model_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc == 2) rst = 0;
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL reset cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    for (int cyc = 0; cyc < 6; cyc++) begin
      clear_in();
      case (cyc)
        0: begin idex_rd = 5; idex_memread = 1; idex_regwrite = 1; ifid_rs1 = 5; ifid_use_rs1 = 1; end
        2: begin idex_memread = 1; idex_regwrite = 1; ifid_use_rs1 = 1; end
        3: begin idex_rd = 5; idex_memread = 1; ifid_rs1 = 5; ifid_rs2 = 5; ifid_use_rs2 = 1; end
        4: begin idex_rd = 5; idex_memread = 1; ifid_rs1 = 5; ifid_rs2 = 3; ifid_use_rs2 = 1; end
        default: ;
      endcase
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL load_use cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_alu_branch();
    for (int cyc = 0; cyc < 3; cyc++) begin
      clear_in();
      if (cyc == 0) begin
        ifid_is_branch = 1; ifid_rs2 = 7; ifid_use_rs2 = 1; idex_rd = 7; idex_regwrite = 1;
      end
      if (cyc == 1) begin
        ifid_is_branch = 1; ifid_rs1 = 7; ifid_use_rs1 = 1; exmem_rd = 7; exmem_memread = 1;
      end
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL alu_branch cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_load_branch();
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc == 0) load_branch_in();
      else if (cyc == 1) load_in_mem();
      else clear_in();
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL load_branch cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 2) load_in_mem(); else clear_in();
      if (cyc == 0 || cyc == 2) br_taken = 1;
      if (cyc == 1) load_branch_in();
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL redirect cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_lb2_freeze();
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 0) load_branch_in();
      else if (cyc < 5) load_in_mem();
      else clear_in();
      if (cyc >= 1 && cyc <= 3) begin dcache_stall = 1; br_taken = (cyc == 2); end
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL lb2_freeze cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_lb2();
    load_branch_in();
    tick();
    clear_in();
    rst = 1;
    model_reset();
    #1;
    exp_a = expect_for(0);
    exp_b = expect_for(1);
    n_tests++;
    if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
      n_fail++;
      $display("[TB] FAIL rst_async: got %h/%h expected %h/%h", obs_a, obs_b, exp_a, exp_b);
    end
    #1;
    rst = 0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL rst_release cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_counters();
    clear_in();
    rst = 1;
    model_reset();
    tick();
    rst = 0;
    icache_stall = 1;
    for (int cyc = 0; cyc < 21; cyc++) begin
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL counters cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
    clear_in();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_in();
      rst            = ($urandom_range(0, 49) == 0);
      ifid_rs1       = 5'($urandom_range(0, 3));
      ifid_rs2       = 5'($urandom_range(0, 3));
      ifid_use_rs1   = 1'($urandom_range(0, 1));
      ifid_use_rs2   = 1'($urandom_range(0, 1));
      ifid_is_branch = 1'($urandom_range(0, 1));
      idex_rd        = 5'($urandom_range(0, 3));
      idex_regwrite  = 1'($urandom_range(0, 1));
      idex_memread   = ($urandom_range(0, 2) == 0);
      exmem_rd       = 5'($urandom_range(0, 3));
      exmem_memread  = ($urandom_range(0, 2) == 0);
      br_taken       = ($urandom_range(0, 7) == 0);
      icache_stall   = ($urandom_range(0, 7) == 0);
      dcache_stall   = ($urandom_range(0, 7) == 0);
      if (rst) model_reset();
      settle();
      n_tests++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("[TB] FAIL random cyc%0d: got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_a, exp_b);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_in();
    model_reset();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_load_branch();
    test_redirect();
    test_lb2_freeze();
    test_reset_mid_lb2();
    test_counters();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
